// File: rtl/alu_mc_if.sv
// Handshake bundle for alu_mc: operand channel (in_valid/in_ready) and
// result channel (out_valid/out_ready), plus a read-only FSM state tap.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer holds its payload stable from
// raising valid until that edge. Ready may change without regard to valid.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             illegal;
  logic [1:0]       dbg_state;

  // ALU side
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags, illegal, dbg_state
  );

  // Execute-stage side
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags, illegal, dbg_state
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: add/sub/logic/barrel shifts in two cycles, iterative
// shift-add multiplier (low or high product) in WIDTH+1 cycles.
// Flags are {Z,C,N,V}. One operation in flight at a time.
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave io_bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_MUL   = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1100;
  localparam logic [3:0] OP_AND   = 4'b1110;

  // EXEC is the one-cycle evaluation step for non-multiply ops, working on
  // the operands captured in IDLE.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_MUL_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  logic [3:0]           r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_result;
  logic [3:0]           r_flags;
  logic                 r_illegal;

  logic [SH_W-1:0]      w_sh;
  logic                 w_sub;
  logic [WIDTH-1:0]     w_b_eff;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c;
  logic                 w_v;
  logic                 w_ill;
  logic [3:0]           w_flags;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_mul_res;
  logic                 w_is_mul_in;

  // SUB reuses the adder as a + ~b + 1 so C reads as "no borrow"
  assign w_sh    = r_b[SH_W-1:0];
  assign w_sub   = (r_op == OP_SUB);
  assign w_b_eff = w_sub ? ~r_b : r_b;
  assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

  // Single-cycle datapath on captured operands
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        // Overflow when effective operands agree in sign and the sum does not
        w_v   = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SLL:  w_res = r_a << w_sh;
      OP_SRL:  w_res = r_a >> w_sh;
      OP_SRA:  w_res = $signed(r_a) >>> w_sh;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_AND:  w_res = r_a & r_b;
      // Multiplies never reach EXEC; listed so they are not flagged illegal
      OP_MUL, OP_MULHU: w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end

  // Illegal ops report all-zero flags, so Z is suppressed for them
  assign w_flags = {(~w_ill) & (w_res == '0), w_c, w_res[WIDTH-1], w_v};

  // One shift-add step and final half selection
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_res   = (r_op == OP_MULHU) ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
  assign w_is_mul_in = (io_bus.op == OP_MUL) || (io_bus.op == OP_MULHU);

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.in_valid) begin
            r_op       <= io_bus.op;
            r_a        <= io_bus.a;
            r_b        <= io_bus.b;
            r_in_ready <= 1'b0;
            if (w_is_mul_in) begin
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, io_bus.a};
              r_mplier <= io_bus.b;
              r_cnt    <= '0;
              r_state  <= S_MUL_RUN;
            end else begin
              r_state  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_result    <= w_res;
          r_flags     <= w_flags;
          r_illegal   <= w_ill;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_MUL_RUN: begin
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_result    <= w_mul_res;
            r_flags     <= {(w_mul_res == '0), 1'b0, w_mul_res[WIDTH-1], 1'b0};
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.result    = r_result;
  assign io_bus.flags     = r_flags;
  assign io_bus.illegal   = r_illegal;
  assign io_bus.dbg_state = r_state;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the core's combinational ALU.
- Keeps the existing arithmetic/logic op encodings and ZCNV flag format.
- Adds barrel shifts and an iterative shift-add multiplier (low/high product).
- Adds a valid/ready handshake on both input and output, so the execute stage can stall on long operations.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), multiplier iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept an operation
op  in  4  operation select (encoding below)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  operation result
flags  out  4  {Z,C,N,V}: bit3 Z, bit2 C, bit1 N, bit0 V
illegal  out  1  op was unsupported; valid with out_valid

Behaviour:
- Op encoding:
  - ADD 0000, SUB 0001, SLL 0010, SRL 0100, SRA 0101, MUL 0110, MULHU 0111, XOR 1000, OR 1100, AND 1110.
  - Any other code is illegal.
- Shift amount is b[$clog2(WIDTH)-1:0]; upper bits of b are ignored.
- Reset (async, any time, including mid-multiply):
  - state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, illegal=0.
  - Counter and accumulators are cleared.
- States:
  - IDLE: in_ready=1. On in_valid, op/a/b are captured.
    - MUL/MULHU: go to MUL_RUN.
    - All other ops, including illegal: result/flags computed and registered, go to DONE.
  - MUL_RUN: in_ready=0. Runs WIDTH iterations of shift-add on a 2*WIDTH accumulator (multiplicand shifted left, multiplier shifted right, one bit per cycle). Then registers low half (MUL) or high half (MULHU) and goes to DONE.
  - DONE: out_valid=1, in_ready=0. result/flags/illegal are held stable until out_valid&&out_ready, then state returns to IDLE.
- Latency:
  - Single-cycle class: accept at edge k, out_valid=1 after edge k+1.
  - MUL/MULHU: out_valid=1 after edge k+WIDTH+1.
  - Throughput is one op per (latency + 1) cycles minimum; there is no overlap of DONE and IDLE.
- Arithmetic:
  - ADD computes a+b; SUB computes a+~b+1, in WIDTH+1 bits.
  - C = bit WIDTH (SUB: C=1 means no borrow).
  - V = signed overflow:
    - ADD: a,b same sign, result differs.
    - SUB: a,b differ in sign, result sign != a sign.
  - Wrap-around is modulo 2^WIDTH.
- Logic, shift and multiply flags:
  - Z = (result==0), N = result[WIDTH-1], C=0, V=0.
  - SRA replicates a[WIDTH-1].
- Illegal op: result=0, flags=0, illegal=1, 1-cycle latency.
- Flags for ADD/SUB are taken from the arithmetic result, which is the same as result.
- in_valid while in_ready=0 is ignored. Inputs are not held by the block; the producer must keep them until the handshake.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset then ADD a=0x7FFFFFFF b=1 -> after 2 edges out_valid=1, result=0x80000000, flags={Z0,C0,N1,V1}; out_ready=1 returns in_ready=1 next cycle.
- SUB a=5 b=5 -> result=0, flags={Z1,C1,N0,V0}. SUB a=0 b=1 -> result=0xFFFFFFFF, flags={Z0,C0,N1,V0}.
- SRA a=0x80000000 b=0x24 (shift 4) -> result=0xF8000000, N=1. SRL same inputs -> 0x08000000. SLL a=1 b=31 -> 0x80000000.
- MUL a=0xFFFFFFFF b=0xFFFFFFFF -> result=0x00000001 after exactly 33 edges. MULHU same inputs -> 0xFFFFFFFE. in_ready=0 throughout; in_valid pulses mid-run are ignored.
- Backpressure: XOR a=0xF0F0 b=0xFFFF with out_ready=0 for 5 cycles -> result=0x0F0F held constant, out_valid stays 1. Release -> one transfer only.
- Assert rst at cycle 10 of a MUL -> out_valid=0, in_ready=1 immediately. A subsequent ADD 2+3 yields 5. Op=0011 -> illegal=1, result=0. Rerun with WIDTH=8: ADD 0xFF+0x01 -> result=0x00, flags={Z1,C1,N0,V0}.
